vdu_ram_arbiter: RTL and testbench
==================================

// Module: vdu_ram_arbiter
// PURPOSE
//  Shares the single-port VDU display RAM between the CPU bus (mk14_soc) and the VDU fetch path.
//  CPU has priority; an aging counter guarantees the VDU a grant within MAX_VDU_WAIT cycles.
//  Both requesters use absolute 16-bit addresses. The arbiter translates them into the RAM window.
//  Out-of-window accesses are completed without touching RAM.
// PARAMETERS
//  BASE_ADDR     'h0200  first absolute address of display RAM
//  RAM_DEPTH     512     RAM words; window = BASE_ADDR .. BASE_ADDR+RAM_DEPTH-1
//  ADDR_W        9       RAM address width, $clog2(RAM_DEPTH)
//  MAX_VDU_WAIT  4       pending-VDU cycles before VDU overrides CPU priority (1..15)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  cpu_req    in   1       CPU request, level, held until cpu_ack
//  cpu_we     in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr   in   16      absolute address; stable while cpu_req
//  cpu_wdata  in   8       write data
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_rdata  out  8       read data, valid when cpu_ack=1, held until the next CPU ack
//  vdu_req    in   1       VDU read request, level, held until vdu_ack
//  vdu_addr   in   16      absolute address
//  vdu_ack    out  1       one-cycle completion pulse
//  vdu_rdata  out  8       read data, valid when vdu_ack=1, held until the next VDU ack
//  ram_en     out  1       RAM enable
//  ram_we     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM word address
//  ram_wdata  out  8       RAM write data
//  ram_rdata  in   8       synchronous RAM read data, valid 1 cycle after ram_en
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, all outputs 0, aging counter 0.
//    An in-flight transaction is dropped; no ack is issued for it.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE:
//    - IDLE: pick a winner, latch owner/we/addr/wdata/in_window.
//    - ACCESS: ram_en=in_window, ram_we=we&in_window; addr and wdata are driven from registers.
//    - RESP: capture ram_rdata (or 8'h00 if out of window) into the owner's rdata register.
//      Set the owner's ack register.
//  - Latency: req sampled in IDLE at cycle T; RAM enabled at T+1; ack high at T+3.
//    The FSM is back in IDLE at T+3 and may grant again that cycle, giving 3 cycles per access.
//  - In the cycle x_ack=1, x_req from that same requester is ignored (requester drops it next cycle).
//  - Arbitration in IDLE:
//    - VDU wins if vdu_req & (!cpu_req | age==MAX_VDU_WAIT).
//    - Otherwise CPU wins if cpu_req.
//  - Aging counter age[3:0]:
//    - +1 in every cycle where vdu_req is pending (not masked) and the VDU is not the IDLE winner.
//    - Saturates at MAX_VDU_WAIT.
//    - Cleared when the VDU is granted or vdu_req=0.
//  - Window check: in_window = (addr >= BASE_ADDR) && (addr - BASE_ADDR < RAM_DEPTH).
//    Use a 17-bit subtract so there is no wrap.
//    ram_addr = (addr - BASE_ADDR)[ADDR_W-1:0].
//  - Out-of-window: no ram_en, write discarded, read returns 8'h00, ack timing unchanged.
//  - VDU is read-only; there is no vdu_we.
//  - Only one transaction is in flight at a time. ram_en and ram_we are never high outside ACCESS.
//  - Simultaneous req at age<MAX: CPU first, VDU granted at T+3 (its ack at T+6).
//  - Outputs are registered. rdata registers change only on their own ack.
// STRUCTURE
//  - mk14_vdu_pkg holds:
//    - typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t
//    - typedef enum logic {OWN_CPU, OWN_VDU} arb_owner_t
//    - localparam AGE_W = 4
//  - Single module; no sub-module needed (window decode is a function in the package).
//  - Sits in mk14_soc between the CPU bus decode and the display RAM instance.
// TESTING
//  1. Reset mid-ACCESS: CPU read 'h0200, assert rst_n=0 at T+1
//     -> no cpu_ack, all outputs 0, next access normal.
//  2. CPU write 'h0205=8'hA5, then CPU read 'h0205
//     -> ram_addr=5, ram_we pulse once, cpu_ack at T+3, cpu_rdata=8'hA5.
//  3. cpu_req and vdu_req both rise at T, age=0
//     -> cpu_ack at T+3, vdu_ack at T+6, no overlapping ram_en.
//  4. CPU req held continuously (back-to-back), VDU pending
//     -> VDU granted once age hits 4, vdu_ack within 4+6 cycles.
//  5. CPU read 'h01FF and 'h0400
//     -> no ram_en, cpu_ack at T+3, cpu_rdata=8'h00; write to 'h0400 leaves RAM unchanged.
//  6. VDU read 'h03FF (last word)
//     -> ram_addr=9'h1FF, vdu_rdata matches preloaded RAM, vdu_ack exactly one cycle.

Source files
------------

// File: rtl/vdu_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package    : mk14_vdu_pkg
// Description: Shared types and window-decode helpers for the VDU display RAM
//              arbiter (FSM state, transaction owner, aging counter width).
// Revision   : 1.0 - initial release
// ============================================================================
package mk14_vdu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VDU = 1'b1
  } arb_owner_t;

  localparam int AGE_W = 4;

  // 17-bit offset of an absolute address from the window base. An address
  // below the base wraps to a value with bit 16 set, i.e. beyond any depth.
  function automatic logic [16:0] win_offset(input logic [15:0] addr,
                                             input logic [15:0] base);
    return {1'b0, addr} - {1'b0, base};
  endfunction

  // True when the offset lands inside the RAM window.
  function automatic logic win_hit(input logic [16:0] offset,
                                   input logic [16:0] depth);
    return offset < depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vdu_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface  : vdu_ram_arbiter_if
// Description: CPU request bus, VDU fetch bus and display RAM port bundled
//              together. slave = arbiter view, master = environment view.
// Revision   : 1.0 - initial release
// ============================================================================
interface vdu_ram_arbiter_if #(
  parameter int ADDR_W = 9
);
  logic              cpu_req;
  logic              cpu_we;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;
  logic              vdu_req;
  logic [15:0]       vdu_addr;
  logic              vdu_ack;
  logic [7:0]        vdu_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vdu_req, vdu_addr, ram_rdata,
    output cpu_ack, cpu_rdata, vdu_ack, vdu_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vdu_req, vdu_addr, ram_rdata,
    input  cpu_ack, cpu_rdata, vdu_ack, vdu_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/vdu_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : vdu_ram_arbiter
// Description: Shares the single-port VDU display RAM between the CPU bus and
//              the VDU fetch path. CPU has priority; an aging counter lets a
//              starved VDU override it. Absolute addresses are translated
//              into the RAM window; out-of-window accesses complete without
//              touching RAM (reads return 8'h00). Three cycles per access.
// Revision   : 1.0 - initial release
// ============================================================================
module vdu_ram_arbiter
  import mk14_vdu_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'h0200,
  parameter int          RAM_DEPTH    = 512,
  parameter int          ADDR_W       = 9,
  parameter int          MAX_VDU_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vdu_ram_arbiter_if.slave      bus
);

  localparam logic [AGE_W-1:0] C_MAX_AGE = AGE_W'(MAX_VDU_WAIT);
  localparam logic [16:0]      C_DEPTH   = 17'(RAM_DEPTH);

  arb_state_t       r_state;
  arb_owner_t       r_owner;
  logic             r_in_window;
  logic [AGE_W-1:0] r_age;

  logic             w_cpu_req;
  logic             w_vdu_req;
  logic             w_vdu_pend;
  logic             w_vdu_win;
  logic             w_cpu_win;
  logic [15:0]      w_sel_addr;
  logic [16:0]      w_off;
  logic             w_in;

  // Request masking, arbitration and window decode for the IDLE decision.
  always_comb begin
    // A requester's level is ignored in the cycle its ack is high.
    w_cpu_req  = bus.cpu_req & ~bus.cpu_ack;
    w_vdu_req  = bus.vdu_req & ~bus.vdu_ack;
    // A VDU request already being serviced is not waiting.
    w_vdu_pend = w_vdu_req & ~((r_state != IDLE) && (r_owner == OWN_VDU));
    w_vdu_win  = (r_state == IDLE) && w_vdu_req && (!w_cpu_req || (r_age == C_MAX_AGE));
    w_cpu_win  = (r_state == IDLE) && w_cpu_req && !w_vdu_win;
    w_sel_addr = w_vdu_win ? bus.vdu_addr : bus.cpu_addr;
    w_off      = win_offset(w_sel_addr, BASE_ADDR);
    w_in       = win_hit(w_off, C_DEPTH);
  end

  // Arbiter FSM with registered RAM/ack/rdata outputs and the aging counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_owner       <= OWN_CPU;
      r_in_window   <= 1'b0;
      r_age         <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= 8'h00;
      bus.vdu_ack   <= 1'b0;
      bus.vdu_rdata <= 8'h00;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= 8'h00;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.vdu_ack <= 1'b0;

      if (!w_vdu_pend || w_vdu_win) begin
        r_age <= '0;
      end else if (r_age != C_MAX_AGE) begin
        r_age <= r_age + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_vdu_win || w_cpu_win) begin
            r_owner       <= w_vdu_win ? OWN_VDU : OWN_CPU;
            r_in_window   <= w_in;
            bus.ram_en    <= w_in;
            bus.ram_we    <= w_cpu_win & bus.cpu_we & w_in;
            bus.ram_addr  <= w_off[ADDR_W-1:0];
            bus.ram_wdata <= w_vdu_win ? 8'h00 : bus.cpu_wdata;
            r_state       <= ACCESS;
          end
        end
        ACCESS: begin
          bus.ram_en <= 1'b0;
          bus.ram_we <= 1'b0;
          r_state    <= RESP;
        end
        RESP: begin
          if (r_owner == OWN_VDU) begin
            bus.vdu_rdata <= r_in_window ? bus.ram_rdata : 8'h00;
            bus.vdu_ack   <= 1'b1;
          end else begin
            bus.cpu_rdata <= r_in_window ? bus.ram_rdata : 8'h00;
            bus.cpu_ack   <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vdu_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_vdu_ram_arbiter
// Description: Randomised CPU/VDU traffic against a transaction-level model of
//              the display RAM arbiter, with a mid-access reset.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_vdu_ram_arbiter;

  localparam int BASE  = 'h0200;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int MAXW  = 4;
  localparam int NCYC  = 4000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vdu_ram_arbiter_if #(.ADDR_W(AW)) bus ();

  vdu_ram_arbiter #(
    .BASE_ADDR   (16'h0200),
    .RAM_DEPTH   (DEPTH),
    .ADDR_W      (AW),
    .MAX_VDU_WAIT(MAXW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Synchronous single-port display RAM (read-first).
  logic [7:0] mem  [DEPTH];
  logic [7:0] gold [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected per-cycle events, indexed by cycle modulo 8.
  bit         s_en   [8];
  bit         s_we   [8];
  bit         s_cack [8];
  bit         s_vack [8];
  logic [8:0] s_addr [8];
  logic [7:0] s_wdat [8];
  logic [7:0] s_data [8];

  int         idle_from;
  int         age;
  bit         vdu_svc;
  logic [7:0] exp_crd, exp_vrd;
  bit         c_act, v_act;
  int         v_start;
  int         p_cpu;
  bit         cpu_b2b;
  bit         rst_done;

  function automatic logic [15:0] pick_addr();
    logic [15:0] a;
    case ($urandom % 8)
      0: a = 16'h0200;
      1: a = 16'h03FF;
      2: a = 16'h01FF;
      3: a = 16'h0400;
      4: a = 16'h0205;
      5: a = 16'($urandom);
      default: a = 16'($urandom_range(BASE, BASE + DEPTH - 1));
    endcase
    return a;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      s_en[i] = 0; s_we[i] = 0; s_cack[i] = 0; s_vack[i] = 0;
      s_addr[i] = '0; s_wdat[i] = '0; s_data[i] = '0;
    end
    age = 0; vdu_svc = 0; exp_crd = 8'h00; exp_vrd = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {bus.cpu_ack, bus.vdu_ack, bus.ram_en, bus.ram_we, 23'(bus.ram_addr)}, 32'h0);
    check_eq(tag, {bus.cpu_rdata, bus.vdu_rdata, bus.ram_wdata}, 32'h0);
  endtask

  initial begin
    int  k;
    bit  cack_now, vack_now, e_en, e_we;
    bit  m_cpu, m_vdu, pend, idle, vwin, cwin, inw, wr;
    int  a, off;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = 8'($urandom);
      gold[i] = mem[i];
    end
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vdu_req = 0; bus.vdu_addr = '0; bus.ram_rdata = '0;
    clear_model();
    c_act = 0; v_act = 0; v_start = 0; rst_done = 0; cpu_b2b = 0; p_cpu = 30;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    idle_from = 0;

    for (cyc = 1; cyc <= NCYC; cyc++) begin
      @(negedge clk);
      k = cyc % 8;
      if (cyc == 2000) begin p_cpu = 95; cpu_b2b = 1; end

      // Compare this cycle's outputs against the model.
      if (s_cack[k]) exp_crd = s_data[k];
      if (s_vack[k]) exp_vrd = s_data[k];
      check_eq("cpu_ack", bus.cpu_ack, s_cack[k]);
      check_eq("vdu_ack", bus.vdu_ack, s_vack[k]);
      check_eq("ram_en",  bus.ram_en,  s_en[k]);
      check_eq("ram_we",  bus.ram_we,  s_we[k]);
      if (s_en[k]) check_eq("ram_addr", bus.ram_addr, s_addr[k]);
      if (s_we[k]) check_eq("ram_wdata", bus.ram_wdata, s_wdat[k]);
      check_eq("cpu_rdata", bus.cpu_rdata, exp_crd);
      check_eq("vdu_rdata", bus.vdu_rdata, exp_vrd);
      if (s_vack[k]) check_eq("vdu_wait_bound", 32'((cyc - v_start) <= MAXW + 6), 1);
      cack_now = s_cack[k]; vack_now = s_vack[k];
      e_en = s_en[k]; e_we = s_we[k];
      s_en[k] = 0; s_we[k] = 0; s_cack[k] = 0; s_vack[k] = 0;

      if (!rst_done && cyc >= 1500 && e_en && !e_we) begin
        // Reset in the middle of a read's RAM access cycle.
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_access");
        clear_model();
        bus.cpu_req = 0; bus.vdu_req = 0; c_act = 0; v_act = 0;
        repeat (2) @(negedge clk);
        cyc += 2;
        rst_n = 1'b1;
        idle_from = cyc;
        rst_done = 1;
        continue;
      end

      // CPU requester: holds until ack, then drops or issues the next one.
      if (c_act && cack_now) begin
        if (cpu_b2b || ($urandom % 2 == 0)) begin
          bus.cpu_addr = pick_addr(); bus.cpu_we = 1'($urandom); bus.cpu_wdata = 8'($urandom);
        end else begin
          bus.cpu_req = 0; c_act = 0;
        end
      end else if (!c_act && ($urandom % 100 < p_cpu)) begin
        bus.cpu_req = 1; c_act = 1;
        bus.cpu_addr = pick_addr(); bus.cpu_we = 1'($urandom); bus.cpu_wdata = 8'($urandom);
      end
      // VDU requester.
      if (v_act && vack_now) begin
        bus.vdu_req = 0; v_act = 0;
      end else if (!v_act && ($urandom % 100 < 40)) begin
        bus.vdu_req = 1; v_act = 1; v_start = cyc;
        bus.vdu_addr = pick_addr();
      end

      // Reference model: decide what the next clock edge does.
      m_cpu = bus.cpu_req && !cack_now;
      m_vdu = bus.vdu_req && !vack_now;
      idle  = (cyc >= idle_from);
      if (idle) vdu_svc = 0;
      pend  = m_vdu && !vdu_svc;
      vwin  = idle && m_vdu && (!m_cpu || age == MAXW);
      cwin  = idle && m_cpu && !vwin;
      if (!pend || vwin) age = 0;
      else if (age < MAXW) age++;
      if (vwin || cwin) begin
        a   = vwin ? int'(bus.vdu_addr) : int'(bus.cpu_addr);
        wr  = cwin && bus.cpu_we;
        inw = (a >= BASE) && (a < BASE + DEPTH);
        off = inw ? a - BASE : 0;
        s_en[(cyc + 1) % 8]   = inw;
        s_we[(cyc + 1) % 8]   = inw && wr;
        s_addr[(cyc + 1) % 8] = 9'(off);
        s_wdat[(cyc + 1) % 8] = bus.cpu_wdata;
        s_data[(cyc + 3) % 8] = inw ? gold[off] : 8'h00;
        if (inw && wr) gold[off] = bus.cpu_wdata;
        if (vwin) s_vack[(cyc + 3) % 8] = 1;
        else      s_cack[(cyc + 3) % 8] = 1;
        vdu_svc   = vwin;
        idle_from = cyc + 3;
      end
    end

    // RAM contents must match the in-window writes only.
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== gold[i]) bad++;
      check_eq("ram_contents", bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
